// File: rtl/alu_cmd_issue.sv
// rtl/alu_cmd_issue.sv - command FIFO and registered result stage in front of an 8-bit combinational ALU
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake (ready = FIFO not full)
//   cmd_a_i, cmd_b_i, cmd_op_i       command operands and opcode
//   alu_a_o, alu_b_o, alu_op_o       FIFO head to the ALU (zero when FIFO empty)
//   alu_res_i                        combinational ALU result for the head
//   res_valid_o/res_ready_i          result handshake
//   res_data_o, res_op_o             captured result and the opcode that produced it
//   level_o                          FIFO occupancy
//   done_cnt_o                       wrapping count of consumed results
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [7:0]               cmd_a_i,
  input  logic [7:0]               cmd_b_i,
  input  logic [2:0]               cmd_op_i,
  output logic [7:0]               alu_a_o,
  output logic [7:0]               alu_b_o,
  output logic [2:0]               alu_op_o,
  input  logic [7:0]               alu_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [7:0]               res_data_o,
  output logic [2:0]               res_op_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         done_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]       mem_a_q  [DEPTH];
  logic [7:0]       mem_b_q  [DEPTH];
  logic [2:0]       mem_op_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [2:0]       res_op_q, res_op_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic full, empty, push, pop, consume;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // Ready is a pure function of occupancy: a full FIFO never accepts in
  // the same cycle it pops, which keeps ready free of res_ready_i paths.
  assign push    = cmd_valid_i & ~full;
  // The head moves into the result stage whenever that stage is empty or
  // is being emptied by the consumer this cycle.
  assign pop     = ~empty & (~res_valid_q | res_ready_i);
  assign consume = res_valid_q & res_ready_i;

  assign cmd_ready_o = ~full;
  assign alu_a_o     = empty ? 8'h00 : mem_a_q[rd_ptr_q];
  assign alu_b_o     = empty ? 8'h00 : mem_b_q[rd_ptr_q];
  assign alu_op_o    = empty ? 3'b000 : mem_op_q[rd_ptr_q];
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_op_o    = res_op_q;
  assign level_o     = level_q;
  assign done_cnt_o  = done_cnt_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    done_cnt_d  = done_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res_i;
      res_op_d    = alu_op_o;
    end else if (consume) begin
      // Drained with nothing behind it: data registers keep their value.
      res_valid_d = 1'b0;
    end

    if (consume) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_op_q    <= 3'b000;
      done_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the
  // pointers and level are cleared, and the head outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_a_q[wr_ptr_q]  <= cmd_a_i;
      mem_b_q[wr_ptr_q]  <= cmd_b_i;
      mem_op_q[wr_ptr_q] <= cmd_op_i;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb/tb_alu_cmd_issue.sv - scoreboard bench for alu_cmd_issue with a behavioural ALU
module tb_alu_cmd_issue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_a_i, cmd_b_i;
  logic [2:0] cmd_op_i;
  logic [7:0] alu_a_o, alu_b_o;
  logic [2:0] alu_op_o;
  logic [7:0] alu_res_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [7:0] res_data_o;
  logic [2:0] res_op_o;
  logic [2:0] level_o;
  logic [7:0] done_cnt_o;

  alu_cmd_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_op_o(res_op_o),
    .level_o(level_o), .done_cnt_o(done_cnt_o)
  );

  always #5 clk = ~clk;

  // ADD SUB SLL LSR AND OR XOR EQL
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b[2:0];
      3'd3: return a >> b[2:0];
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  always_comb alu_res_i = alu_f(alu_a_o, alu_b_o, alu_op_o);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] op;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_done;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are sampled on the falling edge (inputs are stable
  // then), the scoreboard is updated, then the rising edge is taken.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      if (res_valid_o && res_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("res_data", {24'h0, res_data_o}, {24'h0, e.data});
          chk("res_op", {29'h0, res_op_o}, {29'h0, e.op});
        end
        exp_done = exp_done + 8'd1;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        e.data = alu_f(cmd_a_i, cmd_b_i, cmd_op_i);
        e.op   = cmd_op_i;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid_i = 1'b1;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_op_i    = op;
  endtask

  logic [7:0] tab_a  [8] = '{8'h10, 8'h01, 8'h22, 8'hFF, 8'h80, 8'hF0, 8'h0F, 8'hAA};
  logic [7:0] tab_b  [8] = '{8'h01, 8'h03, 8'h22, 8'h02, 8'h04, 8'h3C, 8'h30, 8'hFF};
  logic [2:0] tab_op [8] = '{3'd1,  3'd2,  3'd7,  3'd0,  3'd3,  3'd4,  3'd5,  3'd6};
  logic [7:0] held;
  int         accepted;
  int         guard;

  initial begin
    reset_n     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_a_i     = 8'h00;
    cmd_b_i     = 8'h00;
    cmd_op_i    = 3'd0;
    res_ready_i = 1'b1;
    exp_done    = 8'd0;
    step();
    step();
    reset_n = 1'b1;

    // reset state
    chk("rst_level", {29'h0, level_o}, 32'd0);
    chk("rst_res_valid", {31'h0, res_valid_o}, 32'd0);
    chk("rst_res_data", {24'h0, res_data_o}, 32'd0);
    chk("rst_res_op", {29'h0, res_op_o}, 32'd0);
    chk("rst_done", {24'h0, done_cnt_o}, 32'd0);
    chk("rst_ready", {31'h0, cmd_ready_o}, 32'd1);
    chk("rst_alu_a_empty", {24'h0, alu_a_o}, 32'd0);

    // single ADD, two-cycle latency
    drive(8'h05, 8'h03, 3'd0);
    step();
    cmd_valid_i = 1'b0;
    chk("lat_valid_k", {31'h0, res_valid_o}, 32'd0);
    chk("lat_head_a", {24'h0, alu_a_o}, 32'h05);
    chk("lat_level_k", {29'h0, level_o}, 32'd1);
    step();
    chk("lat_valid_k1", {31'h0, res_valid_o}, 32'd1);
    chk("lat_data", {24'h0, res_data_o}, 32'h08);
    chk("lat_level_k1", {29'h0, level_o}, 32'd0);
    step();
    chk("lat_drained", {31'h0, res_valid_o}, 32'd0);
    chk("lat_done", {24'h0, done_cnt_o}, {24'h0, exp_done});
    chk("lat_data_kept", {24'h0, res_data_o}, 32'h08);

    // back-to-back table, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(tab_a[i], tab_b[i], tab_op[i]);
      step();
      chk("b2b_level", {29'h0, level_o}, 32'd1);
      if (i > 0) chk("b2b_valid", {31'h0, res_valid_o}, 32'd1);
    end
    cmd_valid_i = 1'b0;
    step();
    step();
    chk("b2b_done", {24'h0, done_cnt_o}, 32'd9);
    chk("b2b_sb_empty", sb.size(), 32'd0);

    // fill with the consumer stalled
    res_ready_i = 1'b0;
    accepted    = 0;
    guard       = 0;
    while (cmd_ready_o && guard < 20) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom));
      step();
      accepted++;
      guard++;
    end
    chk("fill_accepted", accepted, DEPTH + 1);
    chk("fill_level", {29'h0, level_o}, DEPTH);
    chk("fill_ready", {31'h0, cmd_ready_o}, 32'd0);
    chk("fill_valid", {31'h0, res_valid_o}, 32'd1);
    held = res_data_o;
    step();
    chk("hold_data", {24'h0, res_data_o}, {24'h0, held});
    chk("hold_level", {29'h0, level_o}, DEPTH);

    // full: push waits for the pop to free a slot
    drive(8'h40, 8'h02, 3'd1);
    res_ready_i = 1'b1;
    step();
    chk("full_pop_level", {29'h0, level_o}, DEPTH - 1);
    chk("full_pop_ready", {31'h0, cmd_ready_o}, 32'd1);
    res_ready_i = 1'b0;
    step();
    cmd_valid_i = 1'b0;
    chk("full_push_level", {29'h0, level_o}, DEPTH);
    res_ready_i = 1'b1;
    guard = 0;
    while ((sb.size() != 0) && guard < 20) begin
      step();
      guard++;
    end
    chk("drain_sb_empty", sb.size(), 32'd0);
    step();
    chk("drain_level", {29'h0, level_o}, 32'd0);
    chk("drain_valid", {31'h0, res_valid_o}, 32'd0);
    chk("drain_done", {24'h0, done_cnt_o}, {24'h0, exp_done});

    // reset with work in flight
    res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 8'h01, 3'd0);
      step();
    end
    cmd_valid_i = 1'b0;
    chk("pre_rst_level", {29'h0, level_o}, 32'd3);
    chk("pre_rst_valid", {31'h0, res_valid_o}, 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    sb.delete();
    exp_done = 8'd0;
    chk("mid_rst_level", {29'h0, level_o}, 32'd0);
    chk("mid_rst_valid", {31'h0, res_valid_o}, 32'd0);
    chk("mid_rst_done", {24'h0, done_cnt_o}, 32'd0);
    chk("mid_rst_ready", {31'h0, cmd_ready_o}, 32'd1);
    chk("mid_rst_alu_op", {29'h0, alu_op_o}, 32'd0);

    // counter wrap after 256 consumed results
    res_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom));
      step();
    end
    cmd_valid_i = 1'b0;
    step();
    chk("wrap_255", {24'h0, done_cnt_o}, 32'hFF);
    step();
    chk("wrap_0", {24'h0, done_cnt_o}, 32'h00);
    chk("wrap_sb_empty", sb.size(), 32'd0);
    chk("wrap_valid", {31'h0, res_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
